// File: rtl/pc_sequencer.sv
// pc_sequencer: PC hold/recovery sequencing with I-miss tracking and perf counters
module pc_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_miss,
  input  logic             i_ready,
  input  logic             d_req,
  input  logic             d_ready,
  input  logic             load_use,
  input  logic             mispredict,
  input  logic [15:0]      resolved_target,
  input  logic             pred_jump,
  input  logic [15:0]      pred_target,
  input  logic             perf_clr,
  output logic             stall,
  output logic             stall_pc,
  output logic             stall_mem,
  output logic             bubble,
  output logic [15:0]      pc_recovered,
  output logic             jump,
  output logic [15:0]      jump_target,
  output logic [1:0]       fsm_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [7:0]       flush_count
);
  typedef enum logic [1:0] {RUN = 2'd0, IMISS = 2'd1, RECOVER = 2'd2} state_t;
  state_t state, state_nxt;
  logic drop_fill, drop_nxt, accept;
  // hold controls and fetch-redirect outputs derived from current state
  always_comb begin
    stall_mem   = d_req & ~d_ready;
    stall       = load_use & ~stall_mem;
    stall_pc    = (state == IMISS) | ((state == RUN) & i_miss);
    bubble      = state == RECOVER;
    jump        = pred_jump & (state == RUN) & ~i_miss;
    jump_target = pred_target;
    fsm_state   = state;
    accept      = mispredict & ~stall_mem & (state != RECOVER);
  end
  // next state; a fill that was already in flight when a mispredict hit is swallowed by drop_fill
  always_comb begin
    state_nxt = state;
    drop_nxt  = ((state == IMISS) & accept) ? 1'b1 : i_ready ? 1'b0 : drop_fill;
    case (state)
      RUN:     state_nxt = accept ? RECOVER : i_miss ? IMISS : RUN;
      IMISS:   state_nxt = accept ? RECOVER : (i_ready & ~drop_fill) ? RUN : IMISS;
      default: state_nxt = RUN;
    endcase
  end
  // state, recovery PC and stale-fill flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      drop_fill    <= 1'b0;
      pc_recovered <= '0;
    end else begin
      state     <= state_nxt;
      drop_fill <= drop_nxt;
      if (accept) pc_recovered <= resolved_target;
    end
  end
  // saturating stall counter and wrapping flush counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((stall | stall_pc | stall_mem) & ~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
      if (accept) flush_count <= flush_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven and sequence checks for pc_sequencer
module tb_pc_sequencer;
  localparam int CW = 4;
  logic clk = 0, reset_n = 0;
  logic i_miss = 0, i_ready = 0, d_req = 0, d_ready = 0, load_use = 0;
  logic mispredict = 0, pred_jump = 0, perf_clr = 0;
  logic [15:0] resolved_target = 0, pred_target = 0;
  logic stall, stall_pc, stall_mem, bubble, jump;
  logic [15:0] pc_recovered, jump_target;
  logic [1:0] fsm_state;
  logic [CW-1:0] stall_cycles;
  logic [7:0] flush_count;
  int total = 0, bad = 0;

  pc_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .i_miss(i_miss), .i_ready(i_ready),
    .d_req(d_req), .d_ready(d_ready), .load_use(load_use),
    .mispredict(mispredict), .resolved_target(resolved_target),
    .pred_jump(pred_jump), .pred_target(pred_target), .perf_clr(perf_clr),
    .stall(stall), .stall_pc(stall_pc), .stall_mem(stall_mem), .bubble(bubble),
    .pc_recovered(pc_recovered), .jump(jump), .jump_target(jump_target),
    .fsm_state(fsm_state), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic i_miss, d_req, d_ready, load_use, pred_jump;
    logic [15:0] tgt;
    logic e_stall, e_pc, e_mem, e_jump;
  } vec_t;
  vec_t vecs[8];
  vec_t sb[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 0, 0, 16'h1111, 0, 0, 1, 0};
    vecs[2] = '{0, 1, 1, 0, 0, 16'h2222, 0, 0, 0, 0};
    vecs[3] = '{0, 0, 0, 1, 0, 16'h3333, 1, 0, 0, 0};
    vecs[4] = '{0, 1, 0, 1, 0, 16'h4444, 0, 0, 1, 0};
    vecs[5] = '{1, 0, 0, 0, 0, 16'h5555, 0, 1, 0, 0};
    vecs[6] = '{0, 0, 0, 0, 1, 16'hBEEF, 0, 0, 0, 1};
    vecs[7] = '{1, 0, 0, 1, 1, 16'hCAFE, 1, 1, 0, 0};

    #3;
    chk("rst_state", fsm_state, 0);
    chk("rst_pc", pc_recovered, 0);
    chk("rst_cnt", stall_cycles, 0);
    chk("rst_flush", flush_count, 0);
    chk("rst_bubble", bubble, 0);
    reset_n = 1;

    foreach (vecs[k]) begin
      @(negedge clk);
      {i_miss, d_req, d_ready, load_use, pred_jump} =
        {vecs[k].i_miss, vecs[k].d_req, vecs[k].d_ready, vecs[k].load_use, vecs[k].pred_jump};
      pred_target = vecs[k].tgt;
      sb.push_back(vecs[k]);
      #1;
      begin
        vec_t e;
        e = sb.pop_front();
        chk($sformatf("v%0d_stall", k), stall, e.e_stall);
        chk($sformatf("v%0d_stall_pc", k), stall_pc, e.e_pc);
        chk($sformatf("v%0d_stall_mem", k), stall_mem, e.e_mem);
        chk($sformatf("v%0d_jump", k), jump, e.e_jump);
        chk($sformatf("v%0d_jtgt", k), jump_target, e.tgt);
      end
      {i_miss, d_req, d_ready, load_use, pred_jump} = '0;
    end
    chk("tbl_state", fsm_state, 0);

    tick();
    perf_clr = 1;
    tick();
    perf_clr = 0;
    chk("clr_cnt", stall_cycles, 0);
    i_miss = 1;
    #1;
    chk("im_pc0", stall_pc, 1);
    chk("im_st0", fsm_state, 0);
    tick();
    i_miss = 0;
    chk("im_st1", fsm_state, 1);
    chk("im_pc1", stall_pc, 1);
    repeat (3) tick();
    i_ready = 1;
    #1;
    chk("im_pc4", stall_pc, 1);
    tick();
    i_ready = 0;
    chk("im_st_run", fsm_state, 0);
    chk("im_pc_off", stall_pc, 0);
    chk("im_cnt5", stall_cycles, 5);

    mispredict = 1;
    resolved_target = 16'h0123;
    tick();
    mispredict = 0;
    chk("mp_bubble", bubble, 1);
    chk("mp_state", fsm_state, 2);
    chk("mp_pc", pc_recovered, 16'h0123);
    chk("mp_flush", flush_count, 1);
    tick();
    chk("mp_bubble_off", bubble, 0);
    chk("mp_run", fsm_state, 0);
    chk("mp_pc_hold", pc_recovered, 16'h0123);

    mispredict = 1;
    resolved_target = 16'h0456;
    d_req = 1;
    #1;
    chk("dm_stall_mem", stall_mem, 1);
    tick();
    chk("dm_blocked", fsm_state, 0);
    chk("dm_pc_hold", pc_recovered, 16'h0123);
    chk("dm_flush_hold", flush_count, 1);
    d_ready = 1;
    tick();
    chk("dm_rec", fsm_state, 2);
    chk("dm_pc", pc_recovered, 16'h0456);
    chk("dm_flush", flush_count, 2);
    resolved_target = 16'h0999;
    tick();
    mispredict = 0;
    {d_req, d_ready} = '0;
    chk("rec_ign_state", fsm_state, 0);
    chk("rec_ign_pc", pc_recovered, 16'h0456);
    chk("rec_ign_flush", flush_count, 2);

    i_miss = 1;
    tick();
    i_miss = 0;
    mispredict = 1;
    resolved_target = 16'h0200;
    tick();
    mispredict = 0;
    chk("df_rec", fsm_state, 2);
    chk("df_pc", pc_recovered, 16'h0200);
    tick();
    i_miss = 1;
    tick();
    i_miss = 0;
    chk("df_imiss", fsm_state, 1);
    i_ready = 1;
    tick();
    i_ready = 0;
    chk("df_stale", fsm_state, 1);
    tick();
    chk("df_wait", fsm_state, 1);
    i_ready = 1;
    tick();
    i_ready = 0;
    chk("df_fill", fsm_state, 0);

    perf_clr = 1;
    tick();
    perf_clr = 0;
    load_use = 1;
    repeat (20) tick();
    chk("sat_cnt", stall_cycles, 15);
    perf_clr = 1;
    tick();
    perf_clr = 0;
    load_use = 0;
    chk("sat_clr", stall_cycles, 0);
    chk("sat_clr_flush", flush_count, 0);

    for (int n = 0; n < 255; n++) begin
      mispredict = 1;
      tick();
      mispredict = 0;
      tick();
    end
    chk("fl_255", flush_count, 255);
    mispredict = 1;
    tick();
    mispredict = 0;
    chk("fl_wrap", flush_count, 0);
    tick();

    i_miss = 1;
    tick();
    i_miss = 0;
    load_use = 1;
    tick();
    load_use = 0;
    chk("ri_imiss", fsm_state, 1);
    reset_n = 0;
    #1;
    chk("ri_state", fsm_state, 0);
    chk("ri_pc_off", stall_pc, 0);
    chk("ri_cnt", stall_cycles, 0);
    chk("ri_flush", flush_count, 0);
    chk("ri_pcrec", pc_recovered, 0);
    i_miss = 1;
    #1;
    chk("ri_pc_follow", stall_pc, 1);
    i_miss = 0;
    @(negedge clk);
    reset_n = 1;
    tick();
    chk("ri_after", fsm_state, 0);
    chk("ri_no_bubble", bubble, 0);

    mispredict = 1;
    resolved_target = 16'h0777;
    tick();
    mispredict = 0;
    chk("rr_rec", bubble, 1);
    reset_n = 0;
    #1;
    chk("rr_bubble", bubble, 0);
    @(negedge clk);
    reset_n = 1;
    tick();
    chk("rr_after", bubble, 0);
    chk("rr_state", fsm_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: CNT_W, 16, width of stall_cycles counter.
REQ-002 One clock; reset is asynchronous and active-low: clk input 1, rising-edge clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 i_miss  input  1  I-cache miss on current fetch.
REQ-005 i_ready  input  1  I-cache fill complete, one-cycle pulse.
REQ-006 d_req  input  1  MEM-stage data access active.
REQ-007 d_ready  input  1  data access complete this cycle.
REQ-008 load_use  input  1  ID-stage load-use hazard.
REQ-009 mispredict  input  1  EX-stage branch mispredict.
REQ-010 resolved_target  input  16  correct PC for mispredict.
REQ-011 pred_jump  input  1  fetch-stage jump request.
REQ-012 pred_target  input  16  fetch-stage jump target.
REQ-013 perf_clr  input  1  synchronous clear of perf counters.
REQ-014 stall, stall_pc, stall_mem  output  1 each  PC hold controls.
REQ-015 bubble  output  1  PC recovery / pipeline flush pulse.
REQ-016 pc_recovered  output  16  registered recovery PC.
REQ-017 jump  output  1; jump_target  output  16.
REQ-018 fsm_state  output  2  RUN=0, IMISS=1, RECOVER=2.
REQ-019 stall_cycles  output  CNT_W; flush_count  output  8.

Function
REQ-020 stall_mem SHALL equal d_req & ~d_ready, combinational, in every state.
REQ-021 stall SHALL equal load_use & ~stall_mem.
REQ-022 stall_pc SHALL equal (state==IMISS) | (state==RUN & i_miss).
REQ-023 bubble SHALL equal (state==RECOVER); exactly one cycle per recovery.
REQ-024 jump SHALL equal pred_jump & (state==RUN) & ~i_miss; jump_target SHALL equal pred_target, unregistered.
REQ-025 Mispredict accepted only when mispredict & ~stall_mem, in RUN or IMISS; ignored in RECOVER.
REQ-026 On accepted mispredict: state <= RECOVER, pc_recovered <= resolved_target, same edge.
REQ-027 RUN: accepted mispredict -> RECOVER; else i_miss -> IMISS; else stay.
REQ-028 IMISS: accepted mispredict -> RECOVER and set drop_fill; else i_ready & ~drop_fill -> RUN; else stay.
REQ-029 RECOVER: unconditionally -> RUN next cycle.
REQ-030 drop_fill (internal) SHALL be cleared by first subsequent i_ready; that i_ready SHALL NOT cause any state transition.
REQ-031 In IMISS with drop_fill set, i_ready clears drop_fill only; state stays IMISS.
REQ-032 Mispredict takes priority over i_miss and i_ready in the same cycle.
REQ-033 pc_recovered SHALL hold its value between recoveries.
REQ-034 stall_cycles SHALL increment each cycle any of stall, stall_pc, stall_mem is 1, saturating at all-ones.
REQ-035 flush_count SHALL increment on each entry to RECOVER, wrapping 255 -> 0.
REQ-036 perf_clr SHALL zero both counters next edge, overriding increments that cycle.

Reset
REQ-037 reset_n low SHALL immediately force state=RUN, pc_recovered=0, drop_fill=0, stall_cycles=0, flush_count=0; combinational outputs follow from these.
REQ-038 Reset asserted mid-IMISS or mid-RECOVER SHALL abandon the operation; no bubble after release.

Verification
REQ-039 i_miss=1 in RUN, i_ready pulse 4 cycles later -> stall_pc high 5 cycles, fsm_state 0->1->0, stall_cycles=5.
REQ-040 mispredict=1, resolved_target=0x0123, d_req=0 -> next cycle bubble=1, pc_recovered=0x0123, flush_count=1, following cycle bubble=0.
REQ-041 mispredict=1 with d_req=1, d_ready=0 -> no RECOVER; retry with d_ready=1 -> RECOVER.
REQ-042 Mispredict in IMISS, then new i_miss after RECOVER, stale i_ready -> remains IMISS; second i_ready -> RUN.
REQ-043 stall_cycles preloaded near all-ones by long stall -> saturates; perf_clr -> 0 next cycle.
REQ-044 reset_n low during IMISS -> fsm_state=0, stall_pc follows i_miss only, all counters 0.
